// File: rtl/hart_mem_arbiter_pkg.sv
// hart_mem_arbiter_pkg
//   Shared types for the hart memory arbiter slice.
//   owner_e   : which hart port owns an access (fetch or data)
//   mem_req_t : one memory access request (address, byte mask, write data)
//   other_owner() : the port opposite to a given owner (round-robin helper)
package hart_mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // Bit positions used on the two-bit request/grant vectors.
  localparam int IDX_IFETCH = 0;
  localparam int IDX_DATA   = 1;

  typedef enum logic {
    OWN_IFETCH = 1'b0,
    OWN_DATA   = 1'b1
  } owner_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W/8-1:0] wmask;
    logic [MEM_DATA_W-1:0]   wdata;
  } mem_req_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IFETCH) ? OWN_DATA : OWN_IFETCH;
  endfunction

endpackage

// File: rtl/hart_mem_arbiter_if.sv
// hart_mem_arbiter_if
//   Bundles the fetch port (i_*), data port (d_*) and SRAM port (m_*) of the
//   hart memory arbiter.
//   modport slave  : arbiter view (takes hart requests, drives the memory)
//   modport master : environment view (hart plus SRAM model)
interface hart_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_wmask;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_en;
  logic                  m_gnt;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W/8-1:0]   m_wmask;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, m_gnt, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_addr, m_wmask, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, m_gnt, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_addr, m_wmask, m_wdata
  );

endinterface

// File: rtl/hart_mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin arbiter. A sole requester always wins; when both
//   request, the one that did not win the last accepted access wins.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : requests (bit 0 fetch, bit 1 data)
//   advance  : the current winner's access was accepted this cycle
//   gnt[1:0] : one-hot winner (not qualified by advance)
module rr_arb2
  import hart_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e last_q;
  owner_e last_d;
  owner_e winner;

  // The previous winner is the only state; it moves only on an accepted
  // access, so the winner stays fixed while the memory stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_IFETCH;
    end else begin
      last_q <= last_d;
    end
  end

  // Pick the winner and work out the next value of the previous-winner state.
  always_comb begin
    winner = OWN_IFETCH;
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   winner = OWN_IFETCH;
      2'b10:   winner = OWN_DATA;
      2'b11:   winner = other_owner(last_q);
      default: winner = OWN_IFETCH;
    endcase
    if (req != 2'b00) begin
      gnt[IDX_IFETCH] = (winner == OWN_IFETCH);
      gnt[IDX_DATA]   = (winner == OWN_DATA);
      if (advance) begin
        last_d = winner;
      end
    end
  end

endmodule

// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter
//   Shares one single-ported synchronous SRAM between the hart's fetch and data
//   ports with fair round-robin arbitration, and routes the 1-cycle-latency
//   read data back to the port that owns each access.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : fetch, data and SRAM ports (hart_mem_arbiter_if.slave)
//   conflict_cnt : saturating count of cycles where both ports request
module hart_mem_arbiter
  import hart_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hart_mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic [1:0] arb_gnt;
  logic       win_data;
  logic       accepted;
  logic       resp_vld_q;
  owner_e     owner_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.d_req, bus.i_req}),
    .advance (bus.m_gnt),
    .gnt     (arb_gnt)
  );

  // Route the winning request to the memory. Grants are purely a function of
  // requests, m_gnt and the arbiter state, never of m_rdata.
  always_comb begin
    win_data    = arb_gnt[IDX_DATA];
    accepted    = (bus.i_req | bus.d_req) & bus.m_gnt;
    bus.m_en    = bus.i_req | bus.d_req;
    bus.m_addr  = win_data ? bus.d_addr[ADDR_W-1:0] : bus.i_addr[ADDR_W-1:0];
    bus.m_wmask = win_data ? bus.d_wmask : '0;
    bus.m_wdata = win_data ? bus.d_wdata : '0;
    bus.i_gnt   = arb_gnt[IDX_IFETCH] & bus.m_gnt;
    bus.d_gnt   = arb_gnt[IDX_DATA] & bus.m_gnt;
  end

  // Remember who owns the access accepted last cycle so the returning data
  // lands on the right port; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_vld_q <= 1'b0;
      owner_q    <= OWN_IFETCH;
    end else begin
      resp_vld_q <= accepted;
      if (accepted) begin
        owner_q <= win_data ? OWN_DATA : OWN_IFETCH;
      end
    end
  end

  // Response steering; read data is shared and qualified by the rvalids.
  always_comb begin
    bus.i_rvalid = resp_vld_q & (owner_q == OWN_IFETCH);
    bus.d_rvalid = resp_vld_q & (owner_q == OWN_DATA);
    bus.i_rdata  = bus.m_rdata;
    bus.d_rdata  = bus.m_rdata;
  end

  // Contention statistic; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (bus.i_req && bus.d_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // A requester must hold its request and payload until it is granted.
  a_i_hold : assert property (@(posedge clk) disable iff (!rst)
    (bus.i_req && !bus.i_gnt) |=> (bus.i_req && $stable(bus.i_addr)));
  a_d_hold : assert property (@(posedge clk) disable iff (!rst)
    (bus.d_req && !bus.d_gnt) |=> (bus.d_req && $stable(bus.d_addr)
                                   && $stable(bus.d_wmask) && $stable(bus.d_wdata)));

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// tb_hart_mem_arbiter
//   Self-checking bench for hart_mem_arbiter. A reference model (previous
//   winner, a queue of expected responses, a plain conflict tally) predicts
//   every output each cycle. A second instance with a 4-bit counter sees the
//   same stimulus to exercise counter saturation.
module tb_hart_mem_arbiter;
  import hart_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  hart_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  hart_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  hart_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .conflict_cnt(cnt16)
  );

  hart_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .conflict_cnt(cnt4)
  );

  // The small-counter instance mirrors the main stimulus.
  assign bus4.i_req   = bus.i_req;
  assign bus4.i_addr  = bus.i_addr;
  assign bus4.d_req   = bus.d_req;
  assign bus4.d_addr  = bus.d_addr;
  assign bus4.d_wmask = bus.d_wmask;
  assign bus4.d_wdata = bus.d_wdata;
  assign bus4.m_gnt   = bus.m_gnt;
  assign bus4.m_rdata = bus.m_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  owner_e      mdl_last;
  owner_e      resp_q[$];
  int unsigned mdl_conf;
  logic        out_i, out_d;
  logic        exp_ig, exp_dg;

  // Current stimulus
  logic        s_ir, s_dr, s_mg;
  logic [31:0] s_ia, s_da, s_dw, s_rd;
  logic [3:0]  s_dm;

  // Last observed DUT values, for directed checks against constants
  logic        obs_ig, obs_dg, obs_irv, obs_drv, obs_men;
  logic [31:0] obs_maddr, obs_mwdata, obs_irdata;
  logic [3:0]  obs_mwmask;
  logic [15:0] obs_cnt;
  logic [3:0]  obs_cnt4;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mdl_last = OWN_IFETCH;
    resp_q   = {};
    mdl_conf = 0;
    out_i    = 1'b0;
    out_d    = 1'b0;
  endtask

  // Predict every output from the current stimulus and model, and compare.
  task automatic checkOutput();
    logic        win_d;
    logic        exp_irv, exp_drv;
    int unsigned sat16, sat4;
    if (s_ir && s_dr) win_d = (mdl_last == OWN_IFETCH);
    else              win_d = s_dr;
    exp_ig  = s_ir && !win_d && s_mg;
    exp_dg  = s_dr && win_d && s_mg;
    exp_irv = (resp_q.size() != 0) && (resp_q[0] == OWN_IFETCH);
    exp_drv = (resp_q.size() != 0) && (resp_q[0] == OWN_DATA);
    sat16   = (mdl_conf > 65535) ? 65535 : mdl_conf;
    sat4    = (mdl_conf > 15) ? 15 : mdl_conf;

    obs_ig = bus.i_gnt; obs_dg = bus.d_gnt; obs_men = bus.m_en;
    obs_irv = bus.i_rvalid; obs_drv = bus.d_rvalid;
    obs_maddr = bus.m_addr; obs_mwmask = bus.m_wmask; obs_mwdata = bus.m_wdata;
    obs_irdata = bus.i_rdata; obs_cnt = cnt16; obs_cnt4 = cnt4;

    checkValue("i_gnt", bus.i_gnt, exp_ig);
    checkValue("d_gnt", bus.d_gnt, exp_dg);
    checkValue("i_gnt_cnt4", bus4.i_gnt, exp_ig);
    checkValue("d_gnt_cnt4", bus4.d_gnt, exp_dg);
    checkValue("m_en", bus.m_en, s_ir | s_dr);
    if (s_ir || s_dr) begin
      checkValue("m_addr", bus.m_addr, win_d ? s_da : s_ia);
      checkValue("m_wmask", bus.m_wmask, win_d ? s_dm : 4'h0);
      if (win_d) checkValue("m_wdata", bus.m_wdata, s_dw);
    end
    checkValue("i_rvalid", bus.i_rvalid, exp_irv);
    checkValue("d_rvalid", bus.d_rvalid, exp_drv);
    if (exp_irv) checkValue("i_rdata", bus.i_rdata, s_rd);
    if (exp_drv) checkValue("d_rdata", bus.d_rdata, s_rd);
    checkValue("conflict_cnt", cnt16, sat16);
    checkValue("conflict_cnt4", cnt4, sat4);
  endtask

  // One clock cycle: drive after the falling edge, check, advance the model
  // at the rising edge, return at the next falling edge.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic [31:0] da,
                               input logic [3:0] dm, input logic [31:0] dw,
                               input logic mg, input logic [31:0] rd);
    s_ir = ir; s_ia = ia; s_dr = dr; s_da = da; s_dm = dm; s_dw = dw;
    s_mg = mg; s_rd = rd;
    bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_addr = da;
    bus.d_wmask = dm; bus.d_wdata = dw; bus.m_gnt = mg; bus.m_rdata = rd;
    #1;
    checkOutput();
    @(posedge clk);
    resp_q = {};
    if (exp_ig) begin resp_q.push_back(OWN_IFETCH); mdl_last = OWN_IFETCH; end
    if (exp_dg) begin resp_q.push_back(OWN_DATA);   mdl_last = OWN_DATA;   end
    if (ir && dr) mdl_conf++;
    out_i = ir && !exp_ig;
    out_d = dr && !exp_dg;
    @(negedge clk);
  endtask

  // Finish any request still waiting for its grant, memory always ready.
  task automatic drain();
    for (int k = 0; k < 4 && (out_i || out_d); k++) begin
      applyStimulus(out_i, s_ia, out_d, s_da, s_dm, s_dw, 1'b1, $urandom);
    end
    checkValue("drain_done", {out_i, out_d}, 2'b00);
  endtask

  task automatic doReset();
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_gnt = 1'b1;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0;
    bus.m_rdata = '0;
    rst = 1'b0;
    #1;
    checkValue("rst_i_gnt", bus.i_gnt, 1'b0);
    checkValue("rst_d_gnt", bus.d_gnt, 1'b0);
    checkValue("rst_m_en", bus.m_en, 1'b0);
    checkValue("rst_i_rvalid", bus.i_rvalid, 1'b0);
    checkValue("rst_d_rvalid", bus.d_rvalid, 1'b0);
    checkValue("rst_cnt", cnt16, 16'd0);
    checkValue("rst_cnt4", cnt4, 4'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        ir, dr, mg;
    logic [31:0] ia, da, dw;
    logic [3:0]  dm;

    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_gnt = 1'b0;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wmask = '0; bus.d_wdata = '0;
    bus.m_rdata = '0;
    modelReset();
    @(negedge clk);
    doReset();

    // Lone fetch request, data returned to the fetch port the next cycle
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h0);
    checkValue("t1_i_gnt", obs_ig, 1'b1);
    checkValue("t1_m_addr", obs_maddr, 32'h100);
    checkValue("t1_m_wmask", obs_mwmask, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    checkValue("t1_i_rvalid", obs_irv, 1'b1);
    checkValue("t1_i_rdata", obs_irdata, 32'hDEADBEEF);
    checkValue("t1_d_rvalid", obs_drv, 1'b0);

    // Both ports requesting: grants alternate starting with data
    doReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 32'h200, 1, 32'h1000, 0, 0, 1, $urandom);
      checkValue("t2_d_gnt", obs_dg, (c % 2 == 0) ? 1'b1 : 1'b0);
      checkValue("t2_i_gnt", obs_ig, (c % 2 == 1) ? 1'b1 : 1'b0);
    end
    applyStimulus(0, 32'h200, 1, 32'h1000, 0, 0, 1, $urandom);
    checkValue("t2_conflict_cnt", obs_cnt, 16'd4);

    // Memory stalls a data read for three cycles
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 1, 32'h2000, 0, 0, 0, $urandom);
      checkValue("t3_m_en", obs_men, 1'b1);
      checkValue("t3_m_addr", obs_maddr, 32'h2000);
      checkValue("t3_no_d_gnt", obs_dg, 1'b0);
    end
    applyStimulus(0, 0, 1, 32'h2000, 0, 0, 1, $urandom);
    checkValue("t3_d_gnt", obs_dg, 1'b1);

    // Data write, completion on the data port only
    applyStimulus(0, 0, 1, 32'h2004, 4'hF, 32'h12345678, 1, $urandom);
    checkValue("t3_d_rvalid", obs_drv, 1'b1);
    checkValue("t4_m_wmask", obs_mwmask, 4'hF);
    checkValue("t4_m_wdata", obs_mwdata, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, $urandom);
    checkValue("t4_d_rvalid", obs_drv, 1'b1);
    checkValue("t4_i_rvalid", obs_irv, 1'b0);

    // Reset asserted while a response is due; it must vanish at once
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, $urandom);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    #1;
    checkValue("t5_i_rvalid_pre", bus.i_rvalid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkValue("t5_i_rvalid_rst", bus.i_rvalid, 1'b0);
    checkValue("t5_d_rvalid_rst", bus.d_rvalid, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 32'h400, 1, 32'h404, 0, 0, 1, $urandom);
    checkValue("t5_d_first", obs_dg, 1'b1);
    drain();

    // Long contention: the 4-bit counter saturates
    doReset();
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 32'h500, 1, 32'h600, 4'h3, 32'hA5A5A5A5, 1, $urandom);
    end
    drain();
    checkValue("t6_cnt4_sat", obs_cnt4, 4'd15);
    checkValue("t6_cnt16", obs_cnt, 16'd20);

    // Random traffic with random memory stalls
    doReset();
    for (int c = 0; c < 300; c++) begin
      if (out_i) begin ir = 1'b1; ia = s_ia; end
      else begin ir = ($urandom_range(0, 2) != 0); ia = {$urandom_range(0, 1023), 2'b00}; end
      if (out_d) begin dr = 1'b1; da = s_da; dm = s_dm; dw = s_dw; end
      else begin
        dr = ($urandom_range(0, 2) != 0);
        da = {$urandom_range(0, 1023), 2'b00};
        dm = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        dw = $urandom;
      end
      mg = ($urandom_range(0, 3) != 0);
      applyStimulus(ir, ia, dr, da, dm, dw, mg, $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
